// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential 4x4 unsigned multiplier built from the classic shift-add
// datapath ({C, A, Q} with multiplicand M). One partial-product step is
// retired per clock, so a multiply takes four CALC cycles followed by a
// single DONE cycle.
//
// Ports
//   clk    in   1  clock, all state updates on the rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  begin a multiply (only looked at while idle)
//   a      in   4  multiplicand, captured when start is accepted
//   b      in   4  multiplier, captured when start is accepted
//   p      out  8  registered product, held until the next result
//   busy   out  1  high while the multiply steps are running
//   done   out  1  one-cycle pulse, p is valid while it is high
// ---------------------------------------------------------------------------
module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] m_q, m_d;     // multiplicand
  logic [3:0] a_q, a_d;     // accumulator (high half of the product)
  logic [3:0] q_q, q_d;     // multiplier, shifts out as the low half fills
  logic       c_q, c_d;     // carry out of the accumulator add
  logic [2:0] cnt_q, cnt_d; // completed steps
  logic [7:0] p_q, p_d;     // result register

  // Pre-shift value of {C, A} for the current step.
  logic [4:0] sum;
  logic [3:0] addend;
  logic       carry;

  // Ripple adder: A + (Q[0] ? M : 0). Gating the addend covers the
  // "no add" case without a separate mux on the accumulator.
  always_comb begin
    // NOTE: blocking assignments here, so carry ripples bit by bit within
    // the same evaluation; registers below use non-blocking only.
    addend = q_q[0] ? m_q : 4'd0;
    carry  = 1'b0;
    sum    = 5'd0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a_q[i] ^ addend[i] ^ carry;
      carry  = (a_q[i] & addend[i]) | (carry & (a_q[i] ^ addend[i]));
    end
    sum[4] = carry;
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = 4'd0;
          c_d     = 1'b0;
          cnt_d   = 3'd0;
          state_d = CALC;
        end
      end

      CALC: begin
        // Shift {C, A, Q} right by one with 0 entering at C.
        c_d   = 1'b0;
        a_d   = sum[4:1];
        q_d   = {sum[0], q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        // Fourth step: the post-shift {A, Q} is the full product.
        if (cnt_q == 3'd3) begin
          p_d     = {sum[4:1], sum[0], q_q[3:1]};
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, datapath included, is cleared so that p reads
      // zero after reset and an interrupted multiply leaves nothing behind.
      state_q <= IDLE;
      m_q     <= 4'd0;
      a_q     <= 4'd0;
      q_q     <= 4'd0;
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // The carry register is refilled with 0 by every shift, so between steps
  // it always reads zero; it is kept as architectural state but not consumed.
  logic unused_c;
  assign unused_c = c_q;

  assign p    = p_q;
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Stimulus issues multiplies and pushes the expected product together with
// the cycle at which done must appear; a monitor checks busy, done and p
// after every rising edge against the front of that queue.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  shift_add_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .p    (p),
    .busy (busy),
    .done (done)
  );

  typedef struct {
    logic [7:0] prod;
    int         due;   // cycle number at which done must be observed
  } exp_t;

  exp_t sb[$];

  int         cyc = 0;      // rising edges seen so far
  int         checks = 0;
  int         errors = 0;
  int         next_free = 0; // first negedge cycle at which a start is accepted
  logic [7:0] exp_p;
  logic       exp_busy;
  logic       exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_p = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sb.delete();
        exp_p = 8'h00;
      end
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].due - 4) && (cyc < sb[0].due);
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("busy_done_exclusive", busy & done, 1'b0);
      if (exp_done) begin
        exp_p = sb[0].prod;
        void'(sb.pop_front());
      end
      check("p", p, exp_p);
    end
  end

  // Accept one multiply at this negedge. inject selects a CALC cycle
  // (1..5 after issue) in which a=F, b=F, start=1 are driven; noise drives
  // random a/b/start during the rest of the operation.
  task automatic issue(input logic [3:0] ai, input logic [3:0] bi,
                       input bit noise, input int inject);
    int pr;
    pr = int'(ai) * int'(bi);
    a = ai;
    b = bi;
    start = 1'b1;
    sb.push_back('{prod: pr[7:0], due: cyc + 5});
    next_free = cyc + 6;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == inject) begin
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
      end else if (noise) begin
        a = 4'($urandom);
        b = 4'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gap(1);

    // Directed cases.
    issue(4'hF, 4'hF, 1'b0, 0);
    issue(4'hC, 4'hA, 1'b0, 0);
    gap(2);
    issue(4'h0, 4'h9, 1'b0, 0);
    issue(4'h3, 4'h5, 1'b0, 2);
    issue(4'h9, 4'h9, 1'b0, 0);

    // Abort 7*7 with reset sampled at the end of the third CALC cycle.
    a = 4'h7;
    b = 4'h7;
    start = 1'b1;
    sb.push_back('{prod: 8'd49, due: cyc + 5});
    @(negedge clk);
    start = 1'b0;
    gap(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // First start after reset is accepted straight away.
    issue(4'h1, 4'hD, 1'b0, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    a = 4'h5;
    b = 4'h5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    gap(1);

    // start held high for 14 cycles: accepted every 6 cycles.
    a = 4'h2;
    b = 4'h3;
    start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{prod: 8'h06, due: cyc + 5 + 6 * k});
    gap(14);
    start = 1'b0;
    gap(4);

    // Random operands with noise on the inputs while busy.
    for (int n = 0; n < 30; n++) begin
      issue(4'($urandom), 4'($urandom), 1'b1, 0);
      gap($urandom_range(0, 2));
    end

    // Exhaustive sweep of all operand pairs.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        issue(4'(i), 4'(j), 1'b1, 0);
        gap($urandom_range(0, 1));
      end
    end

    gap(8);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
